// File: rtl/ehl_ahb2apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: one AHB transfer at a time becomes an APB SETUP/ACCESS pair.
// Optional ACCESS timeout is enabled with `define EHL_AHB2APB_TIMEOUT_EN.
module ehl_ahb2apb_bridge #(
  parameter int NSLV           = 4,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hready_in,
  input  logic [31:0]       hwdata,
  output logic              hready,
  output logic [1:0]        hresp,
  output logic [31:0]       hrdata,
  output logic [31:0]       paddr,
  output logic [NSLV-1:0]   psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  input  logic [NSLV*32-1:0] prdata,
  input  logic [NSLV-1:0]   pready,
  input  logic [NSLV-1:0]   pslverr,
  output logic [2:0]        dbg_state
);
  localparam int SB = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4,
    S_ERR1   = 3'd5,
    S_ERR2   = 3'd6
  } state_t;

  state_t        state;
  logic [SB-1:0] idx_q;
  logic [SB-1:0] sel_idx;
  logic          accept;
  logic          size_ok;
  logic          cur_ready;
  logic          cur_err;
  logic [31:0]   cur_rdata;
  logic          unused_cfg;

`ifdef EHL_AHB2APB_TIMEOUT_EN
  logic [7:0]    acc_cnt;
`endif

  // Handshake: a transfer is taken only when the bridge itself shows hready=1,
  // so the address phase is consumed in IDLE, DONE or ERR2 and nowhere else.
  assign accept     = hsel & hready_in & htrans[1] & hready;
  assign size_ok    = (hsize <= 3'd2);
  assign sel_idx    = (NSLV == 1) ? '0 : haddr[SEL_LSB +: SB];
  assign dbg_state  = state;
  assign unused_cfg = ^{htrans[0], 8'(TIMEOUT_CYCLES)};

  always_comb begin
    cur_ready = pready[idx_q];
    cur_err   = pslverr[idx_q];
    cur_rdata = prdata[32*idx_q +: 32];
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= S_IDLE;
      hready  <= 1'b1;
      hresp   <= 2'b00;
      hrdata  <= '0;
      paddr   <= '0;
      psel    <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      idx_q   <= '0;
`ifdef EHL_AHB2APB_TIMEOUT_EN
      acc_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR2: begin
          hready <= 1'b1;
          hresp  <= 2'b00;
          state  <= S_IDLE;
          if (accept) begin
            hready <= 1'b0;
            if (size_ok) begin
              state  <= S_LATCH;
              paddr  <= haddr;
              pwrite <= hwrite;
              idx_q  <= sel_idx;
            end else begin
              // Unsupported size: answer ERROR without touching the APB side.
              state <= S_ERR1;
              hresp <= 2'b01;
            end
          end
        end
        S_LATCH: begin
          if (pwrite) pwdata <= hwdata;
          psel  <= NSLV'(1) << idx_q;
          state <= S_SETUP;
        end
        S_SETUP: begin
          penable <= 1'b1;
          state   <= S_ACCESS;
`ifdef EHL_AHB2APB_TIMEOUT_EN
          acc_cnt <= '0;
`endif
        end
        S_ACCESS: begin
          if (cur_ready) begin
            psel    <= '0;
            penable <= 1'b0;
            if (cur_err) begin
              state <= S_ERR1;
              hresp <= 2'b01;
            end else begin
              if (!pwrite) hrdata <= cur_rdata;
              state  <= S_DONE;
              hready <= 1'b1;
            end
          end
`ifdef EHL_AHB2APB_TIMEOUT_EN
          // pready takes priority over the timeout in the same cycle.
          else if (acc_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            psel    <= '0;
            penable <= 1'b0;
            state   <= S_ERR1;
            hresp   <= 2'b01;
          end else begin
            acc_cnt <= acc_cnt + 8'd1;
          end
`endif
        end
        S_ERR1: begin
          hready <= 1'b1;
          state  <= S_ERR2;
        end
        default: begin
          state   <= S_IDLE;
          hready  <= 1'b1;
          hresp   <= 2'b00;
          psel    <= '0;
          penable <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ehl_ahb2apb_bridge.sv
// Directed bench for ehl_ahb2apb_bridge: simple AHB driver, register-per-slave APB model.
module tb_ehl_ahb2apb_bridge;
  localparam int NSLV = 4;

  logic              hclk = 1'b0;
  logic              hreset;
  logic              hsel;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic              hready_in;
  logic [31:0]       hwdata;
  logic              hready;
  logic [1:0]        hresp;
  logic [31:0]       hrdata;
  logic [31:0]       paddr;
  logic [NSLV-1:0]   psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [NSLV*32-1:0] prdata;
  logic [NSLV-1:0]   pready;
  logic [NSLV-1:0]   pslverr;
  logic [2:0]        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int onehot_viol = 0;

  // APB slave model controls
  int              apb_waits = 0;
  logic [NSLV-1:0] err_mask  = '0;
  int              wcnt      = 0;
  logic [31:0]     slave_reg [NSLV];

  // transfer observations
  int          t_waits;
  logic [1:0]  t_resp_w;
  logic [1:0]  t_resp_done;
  logic [31:0] t_rdata;
  logic [3:0]  t_psel_or;
  logic [31:0] t_paddr;
  logic [31:0] t_pwdata;
  logic        t_pwrite;

  ehl_ahb2apb_bridge #(.NSLV(NSLV), .SEL_LSB(12), .TIMEOUT_CYCLES(255)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready_in(hready_in), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 hclk = ~hclk;

  // APB slave model: wait counter reloaded in SETUP, one register per slave
  assign pready  = (wcnt == 0) ? psel : '0;
  assign pslverr = err_mask;
  assign prdata  = {slave_reg[3], slave_reg[2], slave_reg[1], slave_reg[0]};

  initial for (int k = 0; k < NSLV; k++) slave_reg[k] = '0;

  always @(posedge hclk) begin
    if (psel != '0 && !penable) wcnt <= apb_waits;
    else if (penable && wcnt > 0) wcnt <= wcnt - 1;
    for (int k = 0; k < NSLV; k++)
      if (psel[k] && penable && pready[k] && pwrite && !pslverr[k])
        slave_reg[k] <= pwdata;
  end

  always @(negedge hclk)
    if ($countones(psel) > 1) onehot_viol <= onehot_viol + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // driver: present an address phase at a negedge, return at the following negedge
  task automatic ahb_addr(input logic [31:0] addr, input logic wr, input logic [2:0] size);
    hsel = 1'b1; hready_in = 1'b1; htrans = 2'b10;
    haddr = addr; hwrite = wr; hsize = size;
    @(negedge hclk);
  endtask

  // driver: run the data phase until hready returns, recording what the APB side did
  task automatic ahb_data(input logic [31:0] wdata);
    hwdata = wdata; hsel = 1'b0; htrans = 2'b00;
    t_waits = 0; t_psel_or = '0; t_resp_w = 2'bxx;
    t_paddr = 'x; t_pwdata = 'x; t_pwrite = 1'bx;
    while (hready === 1'b0 && t_waits < 1000) begin
      t_psel_or |= psel;
      if (psel != '0) begin
        t_paddr = paddr; t_pwdata = pwdata; t_pwrite = pwrite;
      end
      t_resp_w = hresp;
      t_waits++;
      @(negedge hclk);
    end
    t_resp_done = hresp;
    t_rdata     = hrdata;
  endtask

  initial begin
    hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hready_in = 1'b1; hwdata = '0;
    repeat (3) @(negedge hclk);

    // reset state
    check("rst_hready",  32'(hready),    32'd1);
    check("rst_hresp",   32'(hresp),     32'd0);
    check("rst_hrdata",  hrdata,         32'd0);
    check("rst_psel",    32'(psel),      32'd0);
    check("rst_penable", 32'(penable),   32'd0);
    check("rst_paddr",   paddr,          32'd0);
    check("rst_pwrite",  32'(pwrite),    32'd0);
    check("rst_pwdata",  pwdata,         32'd0);
    check("rst_state",   32'(dbg_state), 32'd0);
    hreset = 1'b0;
    @(negedge hclk);

    // 1: zero-wait write to slave1
    ahb_addr(32'h0000_1004, 1'b1, 3'd2);
    ahb_data(32'hA5A5_0001);
    check("wr1_psel",   32'(t_psel_or), 32'b0010);
    check("wr1_pwdata", t_pwdata,       32'hA5A5_0001);
    check("wr1_paddr",  t_paddr,        32'h0000_1004);
    check("wr1_pwrite", 32'(t_pwrite),  32'd1);
    check("wr1_waits",  32'(t_waits),   32'd3);
    check("wr1_hresp",  32'(t_resp_done), 32'd0);
    @(negedge hclk);
    check("wr1_idle",   32'(dbg_state), 32'd0);

    // 2: preload slave3, then read it with two APB wait cycles
    ahb_addr(32'h0000_3000, 1'b1, 3'd2);
    ahb_data(32'hDEAD_BEEF);
    check("pre3_waits", 32'(t_waits), 32'd3);
    @(negedge hclk);
    apb_waits = 2;
    ahb_addr(32'h0000_3000, 1'b0, 3'd2);
    ahb_data(32'h0000_0000);
    check("rd3_hrdata", t_rdata,         32'hDEAD_BEEF);
    check("rd3_waits",  32'(t_waits),    32'd5);
    check("rd3_psel",   32'(t_psel_or),  32'b1000);
    check("rd3_pwrite", 32'(t_pwrite),   32'd0);
    check("rd3_pwdata_kept", t_pwdata,   32'hDEAD_BEEF);
    check("rd3_hresp",  32'(t_resp_done), 32'd0);
    apb_waits = 0;
    @(negedge hclk);

    // 3: pslverr of unselected slaves is ignored; selected slave0 error gives ERROR
    err_mask = 4'b1101;
    ahb_addr(32'h0000_1000, 1'b1, 3'd2);
    ahb_data(32'h1111_2222);
    check("ign_err_hresp", 32'(t_resp_done), 32'd0);
    check("ign_err_waits", 32'(t_waits),     32'd3);
    @(negedge hclk);
    err_mask = 4'b0001;
    ahb_addr(32'h0000_0000, 1'b1, 3'd2);
    ahb_data(32'h3333_4444);
    check("err_resp_wait", 32'(t_resp_w),    32'd1);
    check("err_resp_done", 32'(t_resp_done), 32'd1);
    check("err_waits",     32'(t_waits),     32'd4);
    check("err_psel",      32'(t_psel_or),   32'b0001);
    @(negedge hclk);
    check("err_after_hresp", 32'(hresp),  32'd0);
    check("err_after_state", 32'(dbg_state), 32'd0);
    err_mask = '0;

    // 4: back-to-back write then read of slave2, second accepted in DONE
    ahb_addr(32'h0000_2000, 1'b1, 3'd2);
    ahb_data(32'h1234_5678);
    check("b2b_wr_done", 32'(dbg_state), 32'd4);
    ahb_addr(32'h0000_2000, 1'b0, 3'd2);
    check("b2b_no_idle", 32'(dbg_state), 32'd1);
    ahb_data(32'h0000_0000);
    check("b2b_rdata", t_rdata,       32'h1234_5678);
    check("b2b_waits", 32'(t_waits),  32'd3);
    check("b2b_psel",  32'(t_psel_or), 32'b0100);
    @(negedge hclk);

    // 5: hsize=3 -> ERROR without APB access; BUSY -> no state change
    ahb_addr(32'h0000_1000, 1'b1, 3'd3);
    ahb_data(32'h5555_AAAA);
    check("sz3_psel",      32'(t_psel_or),   32'd0);
    check("sz3_resp_wait", 32'(t_resp_w),    32'd1);
    check("sz3_resp_done", 32'(t_resp_done), 32'd1);
    check("sz3_waits",     32'(t_waits),     32'd1);
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b01; haddr = 32'h0000_1000; hsize = 3'd2;
    @(negedge hclk);
    check("busy_hready", 32'(hready),    32'd1);
    check("busy_hresp",  32'(hresp),     32'd0);
    check("busy_state",  32'(dbg_state), 32'd0);
    check("busy_psel",   32'(psel),      32'd0);
    hsel = 1'b0; htrans = 2'b00;

    // 6: reset while in ACCESS
    apb_waits = 5;
    ahb_addr(32'h0000_1000, 1'b0, 3'd2);
    hsel = 1'b0; htrans = 2'b00;
    for (int i = 0; i < 20 && penable !== 1'b1; i++) @(negedge hclk);
    check("rst_mid_access", 32'(penable), 32'd1);
    hreset = 1'b1;
    @(negedge hclk);
    check("rst_mid_psel",    32'(psel),      32'd0);
    check("rst_mid_penable", 32'(penable),   32'd0);
    check("rst_mid_hready",  32'(hready),    32'd1);
    check("rst_mid_state",   32'(dbg_state), 32'd0);
    check("rst_mid_hrdata",  hrdata,         32'd0);
    hreset = 1'b0;
    apb_waits = 0;
    @(negedge hclk);

`ifdef EHL_AHB2APB_TIMEOUT_EN
    apb_waits = 1000;
    ahb_addr(32'h0000_2000, 1'b0, 3'd2);
    ahb_data(32'h0000_0000);
    check("to_waits",     32'(t_waits),     32'd258);
    check("to_resp_done", 32'(t_resp_done), 32'd1);
    check("to_psel",      32'(psel),        32'd0);
    apb_waits = 0;
    @(negedge hclk);
`endif

    check("psel_onehot", 32'(onehot_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
